// File: rtl/led_frame_scheduler.sv
// Frame sequencer for the serial RGB LED matrix: paces frames, fetches one GRB word per pixel,
// hands words to the serializer, inserts the latch gap and steps the sprite address.
// Optional feature macro: BRIGHTNESS_SCALE_EN (adds brightness[2:0], per-channel right shift in LOAD).
module led_frame_scheduler #(
  parameter int NUM_PIXELS      = 128,
  parameter int LATCH_CYCLES    = 2500,
  parameter int FRAME_CYCLES    = 1000000,
  parameter int FRAMES_PER_ANIM = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  estado,
`ifdef BRIGHTNESS_SCALE_EN
  input  logic [2:0]  brightness,
`endif
  output logic [6:0]  pix_addr,
  input  logic [23:0] pix_color,
  output logic        word_valid,
  output logic [23:0] word_data,
  input  logic        word_ready,
  output logic [3:0]  anim_addr,
  output logic        frame_tick,
  output logic        overrun,
  output logic        busy
);

  localparam int PW = $clog2(FRAME_CYCLES + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int AW = $clog2(FRAMES_PER_ANIM + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   per_cnt;
  logic [LW-1:0]   latch_cnt;
  logic [AW-1:0]   anim_cnt;
  logic            start, hs, last_pix, latch_done;
  logic [3:0]      anim_nxt;
  logic [23:0]     color_cap;

  assign start      = enable && (per_cnt == PW'(FRAME_CYCLES - 1));
  assign hs         = (state == SEND) && word_valid && word_ready;
  assign last_pix   = (pix_addr == 7'(NUM_PIXELS - 1));
  assign latch_done = (state == LATCH) && (latch_cnt == LW'(LATCH_CYCLES - 1));
  assign busy       = (state != IDLE);

`ifdef BRIGHTNESS_SCALE_EN
  assign color_cap = {pix_color[23:16] >> brightness,
                      pix_color[15:8]  >> brightness,
                      pix_color[7:0]   >> brightness};
`else
  assign color_cap = pix_color;
`endif

  // Sprite pairs: idle/happy states bounce 0/1, states 3 and 10 park on 4, the rest bounce 2/3.
  always_comb begin
    anim_nxt = 4'd2;
    case (estado)
      4'd0, 4'd1:  anim_nxt = (anim_addr == 4'd0) ? 4'd1 : 4'd0;
      4'd3, 4'd10: anim_nxt = 4'd4;
      default:     anim_nxt = (anim_addr == 4'd2) ? 4'd3 : 4'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !enable)           per_cnt <= '0;
    else if (start)               per_cnt <= '0;
    else                          per_cnt <= per_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (hs) state_nxt = last_pix ? LATCH : FETCH;
      LATCH:   if (latch_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_addr   <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      anim_addr  <= '0;
      anim_cnt   <= '0;
      latch_cnt  <= '0;
      frame_tick <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      // A wrap landing mid-frame is dropped; the running frame is never cut short.
      overrun    <= start && (state != IDLE);
      case (state)
        IDLE: if (start) pix_addr <= '0;
        LOAD: begin
          word_data  <= color_cap;
          word_valid <= 1'b1;
        end
        SEND: if (hs) begin
          word_valid <= 1'b0;
          if (!last_pix) pix_addr <= pix_addr + 7'd1;
        end
        LATCH: begin
          if (latch_done) begin
            latch_cnt  <= '0;
            frame_tick <= 1'b1;
            if (anim_cnt == AW'(FRAMES_PER_ANIM - 1)) begin
              anim_cnt  <= '0;
              anim_addr <= anim_nxt;
            end else begin
              anim_cnt  <= anim_cnt + AW'(1);
            end
          end else begin
            latch_cnt <= latch_cnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Sequences whole-frame refreshes of the 128-pixel serial RGB LED matrix. Each frame period it fetches one 24-bit GRB word per pixel from the image/need composer and hands the words to the bit serializer over a valid/ready handshake. After the last pixel it inserts the latch gap the LEDs require. It also owns frame-rate pacing and selects the animation sprite address from the pet state.

Parameters:
NUM_PIXELS, 128, pixels per frame (index width = clog2).
LATCH_CYCLES, 2500, clk cycles of idle line after last word (50 us at 50 MHz).
FRAME_CYCLES, 1000000, frame period in clk cycles (20 ms).
FRAMES_PER_ANIM, 5, completed frames per sprite-address update.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  allow new frames to start
estado  in  4  pet state, selects animation sprite pair
pix_addr  out  7  pixel index requested from composer
pix_color  in  24  composer colour; valid 1 cycle after pix_addr changes
word_valid  out  1  word_data valid to serializer
word_data  out  24  colour word, MSB first to serializer
word_ready  in  1  serializer accepts word this cycle
anim_addr  out  4  sprite ROM address for composer
frame_tick  out  1  1-cycle pulse at end of latch gap
overrun  out  1  1-cycle pulse when period expires mid-frame
busy  out  1  high from FETCH through LATCH

Behaviour:
- Reset values: state IDLE; pix_addr, word_data, anim_addr, period counter, anim frame counter all 0; word_valid, frame_tick, overrun, busy all 0. rst mid-frame aborts at the next edge and word_valid drops immediately.
- Period counter: counts 0..FRAME_CYCLES-1 and wraps while enable=1. Held at 0 while enable=0. The wrap cycle is the internal event "start".
- IDLE: on start, set idx=0, pix_addr=0, go to FETCH.
- FETCH: one cycle waiting for composer latency. Go to LOAD.
- LOAD: word_data<=pix_color, word_valid<=1, go to SEND.
- SEND: word_data and word_valid are held stable until the cycle where word_valid and word_ready are both high.
  - On that handshake: word_valid<=0 on the next edge.
  - If idx==NUM_PIXELS-1, go to LATCH.
  - Otherwise idx+1, pix_addr<=idx+1, go to FETCH.
  - Minimum 3 cycles per pixel. word_ready while word_valid=0 is ignored.
- LATCH: word_valid=0 for exactly LATCH_CYCLES cycles. Then frame_tick=1 for one cycle, do the animation update, and go to IDLE.
- busy=1 in FETCH, LOAD, SEND and LATCH.
- Start outside IDLE: the start is dropped, overrun pulses, and the current frame continues.
- enable falling mid-frame: the frame and its latch complete, then the block stays in IDLE.
- Animation update, on each frame completion:
  - If anim frame counter == FRAMES_PER_ANIM-1, clear the counter and update anim_addr; otherwise increment the counter.
  - Update rule, using estado sampled that cycle:
    - estado 0 or 1: anim_addr toggles 0↔1 (any value other than 0 goes to 0).
    - estado 3 or 10: anim_addr becomes 4.
    - Any other estado: anim_addr toggles 2↔3 (any value other than 2 goes to 2).

Optional Feature:
BRIGHTNESS_SCALE_EN
- Defined: adds input port brightness [2:0]. In LOAD, each 8-bit channel of pix_color is logically right-shifted by brightness before capture into word_data. brightness=0 is pass-through; brightness=7 leaves at most 1 LSB per channel. brightness is sampled only in LOAD.
- Undefined: the port is absent and word_data = pix_color exactly.

Test Plan:
Bench parameters: NUM_PIXELS=4, LATCH_CYCLES=10, FRAME_CYCLES=100, FRAMES_PER_ANIM=2.
- Basic frame, word_ready tied 1, pix_color = 0x100000+pix_addr → words 0x100000..0x100003 in order, word_valid low 10 cycles after the 4th handshake, then one frame_tick.
- Backpressure: word_ready low 7 cycles per word → word_data and word_valid stable throughout; each word transferred exactly once; no skipped or duplicated idx.
- Overrun: word_ready low for 120 cycles mid-frame → overrun pulses once at the period wrap; the frame finishes normally; the next frame starts at the following wrap.
- Animation: estado=0 for 4 frames → anim_addr goes 0→1→0 on frames 2 and 4; switch to estado=3 → anim_addr=4 after 2 more frames; estado=5 → 2, then 3.
- Reset/enable: rst asserted in SEND → next cycle word_valid=0, anim_addr=0, busy=0. enable=0 mid-frame → frame completes with frame_tick, then no further word_valid.
- With BRIGHTNESS_SCALE_EN, brightness=2, pix_color=0xFF8040 → word_data=0x3F2010.
